shift_reg: RTL and testbench

Sample-history register for the one-bit sample stream of the instrument's filter datapath. On each accepted sample it forms a new 51-bit history word by shifting the caller-supplied previous history left one place and inserting the new sample bit at bit 0. The result is registered. The block sits between the sample source, which drives `ready_in`, and the filter tap logic, which consumes `shiftreg_new`. The history storage lives outside the block: the parent normally feeds `shiftreg_new` back into `shiftreg_prev`.

---
 rtl/shift_reg.sv | 102 ++++++++++
 tb/tb_shift_reg.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/shift_reg.sv
// shift_reg: sample-history register for a one-bit sample stream.
//
// On each accepted sample the caller-supplied previous history word is shifted
// left one place with the new sample inserted at bit 0, and the result is
// registered. Bit k of the history holds x[n-k] for k = 0..50. The history
// storage itself lives in the parent, which normally feeds shiftreg_new back
// into shiftreg_prev.
//
// Optional feature macro: SHIFTREG_ONES_COUNT_EN adds a registered population
// count of the new history word on ones_count.
//
// Ports:
//   clk            in   1   system clock, rising edge
//   reset_n        in   1   synchronous active-low reset, overrides ready_in
//   ready_in       in   1   sample strobe, x_n is valid this cycle
//   x_n            in   1   current sample bit x[n]
//   shiftreg_prev  in   51  previous history word, sampled only on accept
//   shiftreg_new   out  51  registered updated history word
//   valid_out      out  1   one-cycle pulse, shiftreg_new updated on this edge
//   fill_count     out  6   samples accepted since reset, saturates at 51
//   full           out  1   fill_count has reached 51, sticky until reset
//   ones_count     out  6   popcount of shiftreg_new (SHIFTREG_ONES_COUNT_EN)

module shift_reg (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ready_in,
  input  logic        x_n,
  input  logic [50:0] shiftreg_prev,
  output logic [50:0] shiftreg_new,
  output logic        valid_out,
  output logic [5:0]  fill_count,
  output logic        full
`ifdef SHIFTREG_ONES_COUNT_EN
  ,
  output logic [5:0]  ones_count
`endif
);

  localparam int unsigned Width = 51;
  localparam logic [5:0]  FillMax = 6'd51;

  logic [Width-1:0] r_shift;
  logic             r_valid;
  logic [5:0]       r_fill;
  logic             r_full;

  logic [Width-1:0] w_shift_next;
  logic [5:0]       w_fill_next;

  // Bit 50 of the previous word falls off the top.
  assign w_shift_next = {shiftreg_prev[Width-2:0], x_n};
  assign w_fill_next  = (r_fill == FillMax) ? FillMax : r_fill + 6'd1;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_shift <= '0;
      r_valid <= 1'b0;
      r_fill  <= '0;
      r_full  <= 1'b0;
    end else begin
      r_valid <= ready_in;
      if (ready_in) begin
        r_shift <= w_shift_next;
        r_fill  <= w_fill_next;
        if (w_fill_next == FillMax) begin
          r_full <= 1'b1;
        end
      end
    end
  end

  assign shiftreg_new = r_shift;
  assign valid_out    = r_valid;
  assign fill_count   = r_fill;
  assign full         = r_full;

`ifdef SHIFTREG_ONES_COUNT_EN
  logic [5:0] r_ones;
  logic [5:0] w_ones_next;

  // Count is taken on the word about to be registered so it lines up with
  // shiftreg_new on the same edge.
  always_comb begin
    w_ones_next = '0;
    for (int i = 0; i < Width; i++) begin
      w_ones_next = w_ones_next + {5'd0, w_shift_next[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ones <= '0;
    end else if (ready_in) begin
      r_ones <= w_ones_next;
    end
  end

  assign ones_count = r_ones;
`endif

endmodule

// File: tb/tb_shift_reg.sv
// tb_shift_reg: self-checking bench for shift_reg. A behavioural model keeps
// the history as an integer (shift = multiply by two plus sample, modulo
// 2^51) and the fill level as a plain saturating count.

module tb_shift_reg;

  logic        clk;
  logic        reset_n;
  logic        ready_in;
  logic        x_n;
  logic [50:0] prev_tb;
  logic        fb;
  logic [50:0] shiftreg_prev;
  logic [50:0] shiftreg_new;
  logic        valid_out;
  logic [5:0]  fill_count;
  logic        full;
`ifdef SHIFTREG_ONES_COUNT_EN
  logic [5:0]  ones_count;
`endif

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Model state.
  logic [50:0] m_new;
  logic        m_valid;
  int unsigned m_fill;
  logic        m_full;

  assign shiftreg_prev = fb ? shiftreg_new : prev_tb;

  shift_reg u_dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .ready_in      (ready_in),
    .x_n           (x_n),
    .shiftreg_prev (shiftreg_prev),
    .shiftreg_new  (shiftreg_new),
    .valid_out     (valid_out),
    .fill_count    (fill_count),
    .full          (full)
`ifdef SHIFTREG_ONES_COUNT_EN
    ,
    .ones_count    (ones_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".new"}, {13'd0, shiftreg_new}, {13'd0, m_new});
    check({tag, ".valid"}, {63'd0, valid_out}, {63'd0, m_valid});
    check({tag, ".fill"}, {58'd0, fill_count}, 64'(m_fill));
    check({tag, ".full"}, {63'd0, full}, {63'd0, m_full});
`ifdef SHIFTREG_ONES_COUNT_EN
    check({tag, ".ones"}, {58'd0, ones_count}, 64'($countones(m_new)));
`endif
  endtask

  // One clock: drive inputs, advance the model from the spec rules, compare.
  task automatic cycle(input logic rst_n, input logic rdy, input logic x,
                       input logic [50:0] prev, input logic use_fb, input string tag);
    logic [50:0] eff_prev;
    logic [51:0] wide;
    reset_n  = rst_n;
    ready_in = rdy;
    x_n      = x;
    prev_tb  = prev;
    fb       = use_fb;
    eff_prev = use_fb ? m_new : prev;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      m_new   = '0;
      m_valid = 1'b0;
      m_fill  = 0;
    end else begin
      m_valid = rdy;
      if (rdy) begin
        wide   = {1'b0, eff_prev} * 52'd2 + {51'd0, x};
        m_new  = wide[50:0];
        m_fill = (m_fill + 1 > 51) ? 51 : m_fill + 1;
      end
    end
    m_full = (m_fill == 51);
    check_all(tag);
  endtask

  function automatic logic [50:0] rnd51();
    return {$urandom(), $urandom()} & 64'h7_FFFF_FFFF_FFFF;
  endfunction

  initial begin
    logic [50:0] held;
    m_new = '0; m_valid = 1'b0; m_fill = 0; m_full = 1'b0;
    reset_n = 1'b0; ready_in = 1'b1; x_n = 1'b1; prev_tb = '0; fb = 1'b0;

    // Reset with strobe and sample high: everything stays zero.
    cycle(1'b0, 1'b1, 1'b1, rnd51(), 1'b0, "reset0");
    cycle(1'b0, 1'b1, 1'b1, rnd51(), 1'b0, "reset1");

    // Single shift of the alternating pattern.
    cycle(1'b1, 1'b1, 1'b0, 51'h5_5555_5555_5555, 1'b0, "single");
    check("single.const", {13'd0, shiftreg_new}, {13'd0, 51'h2_AAAA_AAAA_AAAA});
    cycle(1'b1, 1'b0, 1'b1, rnd51(), 1'b0, "single.after");

    // Feedback walk from a clean reset: a lone one climbs to bit 50.
    cycle(1'b0, 1'b0, 1'b0, '0, 1'b0, "walk.rst");
    for (int i = 0; i < 51; i++) begin
      cycle(1'b1, 1'b1, (i == 0), '0, 1'b1, "walk");
    end
    check("walk.bit50", {63'd0, shiftreg_new[50]}, 64'd1);
    check("walk.fill51", {58'd0, fill_count}, 64'd51);
    check("walk.full", {63'd0, full}, 64'd1);
    cycle(1'b1, 1'b1, 1'b0, '0, 1'b1, "walk.52");
    check("walk.52.zero", {13'd0, shiftreg_new}, 64'd0);

    // Idle hold with noisy inputs.
    held = shiftreg_new;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b0, 1'($urandom()), rnd51(), 1'b0, "idle");
    end
    check("idle.held", {13'd0, shiftreg_new}, {13'd0, held});

    // Random traffic, occasional reset and feedback.
    for (int i = 0; i < 300; i++) begin
      cycle(($urandom_range(0, 29) != 0), ($urandom_range(0, 3) != 0), 1'($urandom()),
            rnd51(), 1'($urandom()), "rand");
    end

    // Mid-stream reset after 20 accepts.
    cycle(1'b0, 1'b0, 1'b0, '0, 1'b0, "mid.rst0");
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b1, 1'($urandom()), rnd51(), 1'b0, "mid.fill");
    end
    cycle(1'b0, 1'b1, 1'b1, rnd51(), 1'b0, "mid.rst");
    cycle(1'b1, 1'b1, 1'b1, '0, 1'b0, "mid.first");
    check("mid.first.one", {13'd0, shiftreg_new}, 64'd1);
    check("mid.first.fill", {58'd0, fill_count}, 64'd1);

`ifdef SHIFTREG_ONES_COUNT_EN
    cycle(1'b1, 1'b1, 1'b1, '1, 1'b0, "pop.ones");
    check("pop.51", {58'd0, ones_count}, 64'd51);
    cycle(1'b1, 1'b1, 1'b0, '1, 1'b0, "pop.zero");
    check("pop.50", {58'd0, ones_count}, 64'd50);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
